// File: rtl/register_file_pkg.sv
// ----------------------------------------------------------------------------
// register_file_pkg
//   Shared constants and types for the integer register file.
//   XLEN       : native data width (32)
//   REG_ADDR_W : register index width (5 -> 32 architectural registers)
//   REG_ZERO   : index of the hardwired-zero register x0
//   reg_idx_t  : register index type
// ----------------------------------------------------------------------------
package register_file_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = '0;

endpackage : register_file_pkg

// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
//   Two-read / one-write integer register file with x0 hardwired to zero.
//   Reads are combinational. Writes land on the rising clk edge.
//   The asynchronous reset clears every register immediately.
//
//   Optional feature (compile-time macro REGISTER_FILE_BYPASS_EN):
//     When the macro is defined, a read port whose address matches a pending
//     write (WE3=1, A3!=0, rst=0) returns WD3 combinationally (write-through).
//     When it is undefined, the read port returns the stored value until the
//     write edge.
//
//   Ports
//     clk  : in  1           rising-edge clock
//     rst  : in  1           asynchronous active-high reset
//     WE3  : in  1           write enable, write port 3
//     A1   : in  ADDR_WIDTH  read address, port 1 (rs1)
//     A2   : in  ADDR_WIDTH  read address, port 2 (rs2)
//     A3   : in  ADDR_WIDTH  write address (rd)
//     WD3  : in  DATA_WIDTH  write data
//     RD1  : out DATA_WIDTH  read data, port 1
//     RD2  : out DATA_WIDTH  read data, port 2
// ----------------------------------------------------------------------------
module register_file
    import register_file_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WE3,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int                    NREGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO  = ADDR_WIDTH'(REG_ZERO);

    // Storage exists only for x1..x(NREGS-1); x0 has no flops.
    logic [DATA_WIDTH-1:0] regs [1:NREGS-1];

    // Read view with x0 forced to zero, so both read muxes index one array.
    logic [DATA_WIDTH-1:0] rf_view [NREGS];

    logic write_ok;
    assign write_ok = WE3 && (A3 != ZERO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[A3] <= WD3;
        end
    end

    always_comb begin
        rf_view[0] = '0;
        for (int i = 1; i < NREGS; i++) begin
            rf_view[i] = regs[i];
        end
    end

`ifdef REGISTER_FILE_BYPASS_EN
    // Write-through: a matching pending write is forwarded to the read port.
    // Never for x0 (excluded by write_ok) and never while reset is held.
    logic bypass1;
    logic bypass2;

    assign bypass1 = write_ok && !rst && (A3 == A1);
    assign bypass2 = write_ok && !rst && (A3 == A2);

    assign RD1 = bypass1 ? WD3 : rf_view[A1];
    assign RD2 = bypass2 ? WD3 : rf_view[A2];
`else
    assign RD1 = rf_view[A1];
    assign RD2 = rf_view[A2];
`endif

endmodule : register_file

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of each register and of all data ports.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: register-index width, giving 2**ADDR_WIDTH registers (32 by default).
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port WE3, input, 1 bit: write enable for write port 3.
REQ-006 Port A1, input, ADDR_WIDTH bits: read address, port 1 (rs1).
REQ-007 Port A2, input, ADDR_WIDTH bits: read address, port 2 (rs2).
REQ-008 Port A3, input, ADDR_WIDTH bits: write address (rd).
REQ-009 Port WD3, input, DATA_WIDTH bits: write data, normally the ALU Result or load data.
REQ-010 Port RD1, output, DATA_WIDTH bits: read data 1, driving ALU operand A.
REQ-011 Port RD2, output, DATA_WIDTH bits: read data 2, driving ALU operand B or the store data.

Function
REQ-012 SHALL hold 2**ADDR_WIDTH registers of DATA_WIDTH bits each; register 0 (x0) SHALL be constant zero, with no storage.
REQ-013 Reads SHALL be combinational, with zero-cycle latency: RD1 = reg[A1] and RD2 = reg[A2].
REQ-014 A read of address 0 SHALL return 0 on either port, regardless of any write activity.
REQ-015 On a rising clk edge with WE3=1, rst=0 and A3!=0, reg[A3] SHALL take WD3; the new value SHALL be visible on reads after that edge.
REQ-016 A write with A3=0 SHALL be discarded silently, with no side effect.
REQ-017 With WE3=0, no register SHALL change.
REQ-018 A1 and A2 SHALL be allowed to be equal; both ports SHALL then return the same value.
REQ-019 With A1 or A2 equal to A3 and WE3=1 in the same cycle, the read value before the edge SHALL be as defined in the Configuration section.
REQ-020 Writes SHALL use the full DATA_WIDTH bits; there SHALL be no partial or byte writes.

Reset
REQ-021 While rst=1, all registers SHALL be cleared to 0 immediately, without waiting for a clk edge.
REQ-022 While rst=1, RD1 and RD2 SHALL therefore read 0 for every address.
REQ-023 A write presented on the same edge on which rst is asserted or held SHALL be lost.
REQ-024 The first write SHALL take effect on the first rising edge at which rst=0.

Configuration
REQ-025 With macro REGISTER_FILE_BYPASS_EN defined: when WE3=1, A3!=0 and A3 equals the read address, that read port SHALL return WD3 combinationally (write-through).
REQ-026 With REGISTER_FILE_BYPASS_EN undefined: in the same case, the read port SHALL return the old stored value until the edge.
REQ-027 With REGISTER_FILE_BYPASS_EN defined, bypass SHALL never apply to address 0, and SHALL not apply while rst=1.

Structure
REQ-028 The shared package SHALL hold the XLEN=32 and REG_ADDR_W=5 constants, the REG_ZERO index constant, and the reg_idx_t typedef; the parameter defaults SHALL derive from these.
REQ-029 The module SHALL be implemented as a single module with no sub-module; the bypass mux SHALL be inline, per port.

Verification
REQ-030 Reset: assert rst mid-cycle after writing x5=0xDEADBEEF -> RD1 with A1=5 reads 0 before the next clk edge.
REQ-031 Basic write/read: WE3=1, A3=7, WD3=0x12345678, then one edge -> A1=7 gives RD1=0x12345678 and A2=7 gives RD2=0x12345678.
REQ-032 x0 protection: WE3=1, A3=0, WD3=0xFFFFFFFF, then an edge -> A1=0 gives RD1=0; all other registers are unchanged.
REQ-033 Same-cycle hazard: x3=0x1, then WE3=1, A3=3, WD3=0x2 with A1=3 before the edge -> RD1=0x2 with bypass defined, or RD1=0x1 without it; RD1=0x2 after the edge in both builds.
REQ-034 Write-disable and dual read: WE3=0, A3=4, WD3=0xAA after x4=0x55 -> x4 stays 0x55; A1=A2=4 gives RD1=RD2=0x55.
REQ-035 Sweep: write reg[i]=i*0x01010101 for i=1..31, then read all pairs (i, 31-i) -> each port returns its expected value, and index 0 returns 0.
